// File: rtl/vdp_sprite_line_scanner.sv
`default_nettype none
// ============================================================================
// vdp_sprite_line_scanner - tests every sprite against one raster line and writes the hit list
// Revision 1.0
// ============================================================================
module vdp_sprite_line_scanner #(
   parameter int SPRITE_COUNT   = 256,
   parameter int HIT_LIST_DEPTH = 256,
   parameter int Y_WIDTH        = 9
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              restart,
   input  logic [Y_WIDTH-1:0]                render_y,
   output logic [$clog2(SPRITE_COUNT)-1:0]   sprite_test_id,
   input  logic [Y_WIDTH-1:0]                sprite_y,
   input  logic [1:0]                        height_select,
   input  logic                              flip_y,
   input  logic                              width_select_in,
   output logic                              hit_list_write_en,
   output logic [$clog2(HIT_LIST_DEPTH)-1:0] hit_list_index,
   output logic [$clog2(SPRITE_COUNT)-1:0]   sprite_id,
   output logic [5:0]                        sprite_y_intersect,
   output logic                              width_select_out,
   output logic                              finished,
   output logic                              busy,
   output logic                              overflow,
   output logic [$clog2(HIT_LIST_DEPTH)-1:0] hit_count
);

   localparam int ID_W  = $clog2(SPRITE_COUNT);
   localparam int IDX_W = $clog2(HIT_LIST_DEPTH);
   localparam int CMP_W = (Y_WIDTH > 7) ? Y_WIDTH : 7;

   localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(SPRITE_COUNT - 1);
   localparam logic [IDX_W-1:0] CNT_FINAL = IDX_W'(HIT_LIST_DEPTH - 2);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SCAN      = 2'd1,
      ST_TERMINATE = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

   state_t             state_q;
   logic [Y_WIDTH-1:0] render_y_q;
   logic [ID_W-1:0]    test_id_q;
   logic [ID_W-1:0]    eval_id_q;
   logic               eval_valid_q;
   logic [IDX_W-1:0]   hit_count_q;
   logic [IDX_W-1:0]   index_q;
   logic [ID_W-1:0]    sprite_id_q;
   logic [5:0]         intersect_q;
   logic               width_q;
   logic               write_en_q;
   logic               finished_q;
   logic               busy_q;
   logic               overflow_q;

   logic [Y_WIDTH-1:0] diff;
   logic [CMP_W-1:0]   diff_ext;
   logic [CMP_W-1:0]   height_ext;
   logic [6:0]         height;
   logic [5:0]         row;
   logic               hit;
   logic               last_hit;
   logic               last_sprite;

   // Evaluates the sprite whose Y arrived from the RAM this cycle; the
   // modular subtraction makes sprites straddling the Y wrap point hit.
   always_comb begin
      diff        = render_y_q - sprite_y;
      diff_ext    = CMP_W'(diff);
      height      = 7'd8 << height_select;
      height_ext  = CMP_W'(height);
      hit         = eval_valid_q && (diff_ext < height_ext);
      row         = flip_y ? (6'(height - 7'd1) - diff_ext[5:0]) : diff_ext[5:0];
      last_hit    = hit && (hit_count_q == CNT_FINAL);
      last_sprite = eval_valid_q && (eval_id_q == ID_LAST);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         render_y_q   <= '0;
         test_id_q    <= '0;
         eval_id_q    <= '0;
         eval_valid_q <= 1'b0;
         hit_count_q  <= '0;
         index_q      <= '0;
         sprite_id_q  <= '0;
         intersect_q  <= '0;
         width_q      <= 1'b0;
         write_en_q   <= 1'b0;
         finished_q   <= 1'b0;
         busy_q       <= 1'b0;
         overflow_q   <= 1'b0;
      end else if (restart) begin
         // A new line always wins over any write still pending from the old one.
         state_q      <= ST_SCAN;
         render_y_q   <= render_y;
         test_id_q    <= '0;
         eval_valid_q <= 1'b0;
         hit_count_q  <= '0;
         index_q      <= '0;
         write_en_q   <= 1'b0;
         finished_q   <= 1'b0;
         busy_q       <= 1'b1;
         overflow_q   <= 1'b0;
      end else begin
         write_en_q <= 1'b0;
         finished_q <= 1'b0;
         case (state_q)
            ST_SCAN: begin
               eval_id_q    <= test_id_q;
               eval_valid_q <= 1'b1;
               if (test_id_q != ID_LAST) begin
                  test_id_q <= test_id_q + 1'b1;
               end
               if (hit) begin
                  write_en_q  <= 1'b1;
                  index_q     <= hit_count_q;
                  sprite_id_q <= eval_id_q;
                  intersect_q <= row;
                  width_q     <= width_select_in;
                  hit_count_q <= hit_count_q + 1'b1;
               end
               if (last_hit) begin
                  overflow_q <= 1'b1;
               end
               // Last free slot is reserved for the terminator, so a full list ends the scan early.
               if (last_hit || last_sprite) begin
                  state_q      <= ST_TERMINATE;
                  eval_valid_q <= 1'b0;
               end
            end
            ST_TERMINATE: begin
               write_en_q  <= 1'b1;
               finished_q  <= 1'b1;
               index_q     <= hit_count_q;
               sprite_id_q <= '0;
               intersect_q <= '0;
               width_q     <= 1'b0;
               state_q     <= ST_DONE;
            end
            ST_DONE: begin
               busy_q <= 1'b0;
            end
            default: begin
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign sprite_test_id     = test_id_q;
   assign hit_list_write_en  = write_en_q;
   assign hit_list_index     = index_q;
   assign sprite_id          = sprite_id_q;
   assign sprite_y_intersect = intersect_q;
   assign width_select_out   = width_q;
   assign finished           = finished_q;
   assign busy               = busy_q;
   assign overflow           = overflow_q;
   assign hit_count          = hit_count_q;

endmodule
`default_nettype wire

// File: tb/tb_vdp_sprite_line_scanner.sv
`default_nettype none
// tb_vdp_sprite_line_scanner: directed and random line scans on a default instance and an
// 8-entry hit-list instance, checked cycle by cycle against a per-line expectation table.
module tb_vdp_sprite_line_scanner;

   localparam int SC      = 256;
   localparam int END_CYC = 262;
   localparam int PERIOD  = 10;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       restart;
   logic [8:0] render_y;

   logic [7:0] tid_a, id_a, idx_a, cnt_a;
   logic [8:0] sy_a;
   logic [1:0] hs_a;
   logic       fl_a, ws_a, we_a, wo_a, fin_a, busy_a, ovf_a;
   logic [5:0] row_a;

   logic [7:0] tid_b, id_b;
   logic [2:0] idx_b, cnt_b;
   logic [8:0] sy_b;
   logic [1:0] hs_b;
   logic       fl_b, ws_b, we_b, wo_b, fin_b, busy_b, ovf_b;
   logic [5:0] row_b;

   logic [8:0] ymem [SC];
   logic [1:0] hmem [SC];
   logic       fmem [SC];
   logic       wmem [SC];

   logic exp_we   [2][END_CYC+1];
   logic exp_fin  [2][END_CYC+1];
   logic exp_wid  [2][END_CYC+1];
   logic exp_busy [2][END_CYC+1];
   int   exp_idx  [2][END_CYC+1];
   int   exp_id   [2][END_CYC+1];
   int   exp_row  [2][END_CYC+1];
   int   exp_tid_lim [2];
   int   exp_cnt [2];
   logic exp_ovf [2];

   int   checks   = 0;
   int   failures = 0;
   logic active   = 1'b0;
   time  t0       = 0;

   always #(PERIOD/2) clk = ~clk;

   vdp_sprite_line_scanner dut (
      .clk(clk), .reset_n(reset_n), .restart(restart), .render_y(render_y),
      .sprite_test_id(tid_a), .sprite_y(sy_a), .height_select(hs_a), .flip_y(fl_a),
      .width_select_in(ws_a), .hit_list_write_en(we_a), .hit_list_index(idx_a),
      .sprite_id(id_a), .sprite_y_intersect(row_a), .width_select_out(wo_a),
      .finished(fin_a), .busy(busy_a), .overflow(ovf_a), .hit_count(cnt_a)
   );

   vdp_sprite_line_scanner #(.HIT_LIST_DEPTH(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .restart(restart), .render_y(render_y),
      .sprite_test_id(tid_b), .sprite_y(sy_b), .height_select(hs_b), .flip_y(fl_b),
      .width_select_in(ws_b), .hit_list_write_en(we_b), .hit_list_index(idx_b),
      .sprite_id(id_b), .sprite_y_intersect(row_b), .width_select_out(wo_b),
      .finished(fin_b), .busy(busy_b), .overflow(ovf_b), .hit_count(cnt_b)
   );

   // Sprite attribute RAMs with one cycle of read latency, one port per instance.
   always_ff @(posedge clk) begin
      sy_a <= ymem[tid_a]; hs_a <= hmem[tid_a]; fl_a <= fmem[tid_a]; ws_a <= wmem[tid_a];
      sy_b <= ymem[tid_b]; hs_b <= hmem[tid_b]; fl_b <= fmem[tid_b]; ws_b <= wmem[tid_b];
   end

   // Expected outputs for one line, derived from the list of sprites that cover render_y.
   task automatic build_model(input int d, input int depth, input int ry);
      int n, lastk, t, sy, hs, h, diff;
      logic ovf;
      for (int c = 0; c <= END_CYC; c++) begin
         exp_we[d][c] = 1'b0; exp_fin[d][c] = 1'b0; exp_wid[d][c] = 1'b0; exp_busy[d][c] = 1'b0;
         exp_idx[d][c] = 0; exp_id[d][c] = 0; exp_row[d][c] = 0;
      end
      n = 0; lastk = 0; ovf = 1'b0;
      for (int k = 0; k < SC; k++) begin
         if (ovf) break;
         sy = int'(ymem[k]);
         hs = int'(hmem[k]);
         h = 8 << hs;
         diff = (ry - sy + 512) % 512;
         if (diff < h) begin
            exp_we[d][k+2]  = 1'b1;
            exp_idx[d][k+2] = n;
            exp_id[d][k+2]  = k;
            exp_row[d][k+2] = fmem[k] ? (h - 1 - diff) : diff;
            exp_wid[d][k+2] = wmem[k];
            n++;
            if (n == depth - 1) begin
               ovf = 1'b1;
               lastk = k;
            end
         end
      end
      t = ovf ? lastk + 3 : SC + 2;
      exp_we[d][t]  = 1'b1;
      exp_fin[d][t] = 1'b1;
      exp_idx[d][t] = n;
      for (int c = 0; c <= t; c++) exp_busy[d][c] = 1'b1;
      exp_tid_lim[d] = (ovf && lastk + 1 < SC - 1) ? lastk + 1 : SC - 1;
      exp_cnt[d] = n;
      exp_ovf[d] = ovf;
   endtask

   task automatic fill_mem(input int mode, input int ry);
      for (int i = 0; i < SC; i++) begin
         hmem[i] = 2'($urandom_range(0, 3));
         fmem[i] = 1'($urandom_range(0, 1));
         wmem[i] = 1'($urandom_range(0, 1));
         case (mode)
            0:       ymem[i] = 9'((ry + 256) % 512);
            1:       ymem[i] = 9'(ry);
            default: ymem[i] = ($urandom_range(0, 2) == 0) ? 9'($urandom) :
                               9'((ry + 512 - int'($urandom_range(0, 90))) % 512);
         endcase
      end
   endtask

   task automatic start_line(input int ry);
      @(negedge clk);
      render_y = 9'(ry);
      restart  = 1'b1;
      @(posedge clk);
      t0 = $time;
      #1;
      restart = 1'b0;
      build_model(0, 256, ry);
      build_model(1, 8, ry);
      active = 1'b1;
   endtask

   task automatic finish_line();
      repeat (END_CYC + 1) @(negedge clk);
      #1 active = 1'b0;
   endtask

   // Cycle-accurate scoreboard; cycle 0 is the first cycle after the restart edge.
   always @(negedge clk) begin : sb
      int c, a_idx, a_id, a_row, a_tid;
      logic a_we, a_fin, a_busy, a_wo;
      if (active) begin
         c = int'(($time - t0) / PERIOD);
         if (c <= END_CYC) begin
            for (int d = 0; d < 2; d++) begin
               if (d == 0) begin
                  a_we = we_a; a_fin = fin_a; a_busy = busy_a; a_wo = wo_a;
                  a_idx = int'(idx_a); a_id = int'(id_a); a_row = int'(row_a); a_tid = int'(tid_a);
               end else begin
                  a_we = we_b; a_fin = fin_b; a_busy = busy_b; a_wo = wo_b;
                  a_idx = int'(idx_b); a_id = int'(id_b); a_row = int'(row_b); a_tid = int'(tid_b);
               end
               checks++;
               if (a_we !== exp_we[d][c]) begin
                  failures++;
                  $display("FAIL write_en dut%0d cycle %0d: got %0b expected %0b", d, c, a_we, exp_we[d][c]);
               end else if (exp_we[d][c]) begin
                  checks++;
                  if (a_fin !== exp_fin[d][c] || a_idx != exp_idx[d][c] || a_id != exp_id[d][c] ||
                      a_row != exp_row[d][c] || a_wo !== exp_wid[d][c]) begin
                     failures++;
                     $display("FAIL entry dut%0d cycle %0d: got fin=%0b idx=%0d id=%0d row=%0d w=%0b expected fin=%0b idx=%0d id=%0d row=%0d w=%0b",
                              d, c, a_fin, a_idx, a_id, a_row, a_wo,
                              exp_fin[d][c], exp_idx[d][c], exp_id[d][c], exp_row[d][c], exp_wid[d][c]);
                  end
               end
               checks++;
               if (a_busy !== exp_busy[d][c]) begin
                  failures++;
                  $display("FAIL busy dut%0d cycle %0d: got %0b expected %0b", d, c, a_busy, exp_busy[d][c]);
               end
               if (c <= exp_tid_lim[d]) begin
                  checks++;
                  if (a_tid != c) begin
                     failures++;
                     $display("FAIL test_id dut%0d cycle %0d: got %0d expected %0d", d, c, a_tid, c);
                  end
               end
            end
         end
      end
   end

   task automatic test_reset();
      #1;
      checks++;
      if ({we_a, fin_a, busy_a, ovf_a, wo_a, tid_a, idx_a, id_a, row_a, cnt_a} !== '0 ||
          {we_b, fin_b, busy_b, ovf_b, wo_b, tid_b, idx_b, id_b, row_b, cnt_b} !== '0) begin
         failures++;
         $display("FAIL reset_state: got we=%0b busy=%0b tid=%0d cnt=%0d / we=%0b busy=%0b tid=%0d cnt=%0d expected all zero",
                  we_a, busy_a, tid_a, cnt_a, we_b, busy_b, tid_b, cnt_b);
      end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         checks++;
         if ({we_a, busy_a, tid_a, we_b, busy_b, tid_b} !== '0) begin
            failures++;
            $display("FAIL idle_after_reset: got we=%0b busy=%0b tid=%0d expected 0 0 0", we_a, busy_a, tid_a);
         end
      end
   endtask

   task automatic test_single_hit();
      fill_mem(0, 20);
      ymem[5] = 9'd15; hmem[5] = 2'd0; fmem[5] = 1'b0; wmem[5] = 1'b1;
      start_line(20);
      finish_line();
      checks++;
      if ({ovf_a, cnt_a} !== {1'b0, 8'd1} || {ovf_b, cnt_b} !== {1'b0, 3'd1}) begin
         failures++;
         $display("FAIL single_hit_count: got ovf=%0b cnt=%0d / ovf=%0b cnt=%0d expected 0 1", ovf_a, cnt_a, ovf_b, cnt_b);
      end
   endtask

   task automatic test_flip_wrap();
      fill_mem(0, 20);
      ymem[5] = 9'd15; hmem[5] = 2'd0; fmem[5] = 1'b1;
      start_line(20);
      finish_line();
      fill_mem(0, 10);
      ymem[9] = 9'd500; hmem[9] = 2'd3; fmem[9] = 1'b0;
      start_line(10);
      finish_line();
      checks++;
      if ({ovf_a, cnt_a} !== {1'b0, 8'd1}) begin
         failures++;
         $display("FAIL wrap_hit_count: got ovf=%0b cnt=%0d expected 0 1", ovf_a, cnt_a);
      end
   endtask

   task automatic test_no_hits();
      fill_mem(0, 77);
      start_line(77);
      finish_line();
      checks++;
      if ({ovf_a, cnt_a} !== 9'd0 || {ovf_b, cnt_b} !== 4'd0) begin
         failures++;
         $display("FAIL no_hit_count: got ovf=%0b cnt=%0d / ovf=%0b cnt=%0d expected 0 0", ovf_a, cnt_a, ovf_b, cnt_b);
      end
   endtask

   task automatic test_overflow();
      fill_mem(1, 300);
      start_line(300);
      finish_line();
      checks++;
      if ({ovf_b, cnt_b} !== {1'b1, 3'd7} || {ovf_a, cnt_a} !== {1'b1, 8'd255}) begin
         failures++;
         $display("FAIL overflow_state: got ovf=%0b cnt=%0d / ovf=%0b cnt=%0d expected 1 255 / 1 7", ovf_a, cnt_a, ovf_b, cnt_b);
      end
   endtask

   task automatic test_random();
      int ry;
      for (int n = 0; n < 5; n++) begin
         ry = int'($urandom_range(0, 511));
         fill_mem(2, ry);
         start_line(ry);
         finish_line();
         checks++;
         if (cnt_a !== 8'(exp_cnt[0]) || ovf_a !== exp_ovf[0] || cnt_b !== 3'(exp_cnt[1]) || ovf_b !== exp_ovf[1]) begin
            failures++;
            $display("FAIL random_line%0d: got cnt=%0d ovf=%0b / cnt=%0d ovf=%0b expected %0d %0b / %0d %0b",
                     n, cnt_a, ovf_a, cnt_b, ovf_b, exp_cnt[0], exp_ovf[0], exp_cnt[1], exp_ovf[1]);
         end
      end
   endtask

   task automatic test_back_to_back();
      // Restart while the terminator is pending, then restart mid-scan over a pending hit.
      fill_mem(0, 150);
      start_line(150);
      repeat (257) @(negedge clk);
      fill_mem(2, 150);
      ymem[99] = 9'd150;
      start_line(150);
      repeat (100) @(negedge clk);
      start_line(200);
      finish_line();
      checks++;
      if (cnt_a !== 8'(exp_cnt[0]) || ovf_a !== exp_ovf[0]) begin
         failures++;
         $display("FAIL restart_line: got cnt=%0d ovf=%0b expected %0d %0b", cnt_a, ovf_a, exp_cnt[0], exp_ovf[0]);
      end
   endtask

   task automatic test_reset_mid_scan();
      fill_mem(2, 40);
      start_line(40);
      repeat (50) @(negedge clk);
      @(posedge clk);
      #2;
      active  = 1'b0;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({we_a, fin_a, busy_a, ovf_a, wo_a, tid_a, idx_a, id_a, row_a, cnt_a} !== '0 ||
          {we_b, fin_b, busy_b, ovf_b, wo_b, tid_b, idx_b, id_b, row_b, cnt_b} !== '0) begin
         failures++;
         $display("FAIL async_reset: got we=%0b busy=%0b tid=%0d cnt=%0d expected all zero", we_a, busy_a, tid_a, cnt_a);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         checks++;
         if ({we_a, busy_a, tid_a, we_b, busy_b, tid_b} !== '0) begin
            failures++;
            $display("FAIL idle_after_abort: got we=%0b busy=%0b tid=%0d expected 0 0 0", we_a, busy_a, tid_a);
         end
      end
      start_line(40);
      finish_line();
      checks++;
      if (cnt_a !== 8'(exp_cnt[0]) || ovf_a !== exp_ovf[0]) begin
         failures++;
         $display("FAIL line_after_abort: got cnt=%0d ovf=%0b expected %0d %0b", cnt_a, ovf_a, exp_cnt[0], exp_ovf[0]);
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      restart  = 1'b0;
      render_y = '0;
      fill_mem(0, 0);
      test_reset();
      test_single_hit();
      test_flip_wrap();
      test_no_hits();
      test_overflow();
      test_random();
      test_back_to_back();
      test_reset_mid_scan();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #(PERIOD * 20000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/vdp_sprite_line_scanner.md
VDP_SPRITE_LINE_SCANNER -- requirements
Module: vdp_sprite_line_scanner

Interface
REQ-001 SHALL have parameter SPRITE_COUNT, default 256: sprites tested per line; ID_W = clog2(SPRITE_COUNT).
REQ-002 SHALL have parameter HIT_LIST_DEPTH, default 256: hit-list entries including terminator; IDX_W = clog2(HIT_LIST_DEPTH).
REQ-003 SHALL have parameter Y_WIDTH, default 9: width of raster and sprite Y.
REQ-004 SHALL have one clock, and reset SHALL be asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 restart  in  1  single-cycle pulse that begins a new line scan.
REQ-008 render_y  in  Y_WIDTH  raster line being prepared; sampled on restart.
REQ-009 sprite_test_id  out  ID_W  y-block read address (sync RAM, 1-cycle latency).
REQ-010 sprite_y  in  Y_WIDTH  sprite Y for the address presented one cycle earlier.
REQ-011 height_select  in  2  sprite height: 0=8, 1=16, 2=32, 3=64.
REQ-012 flip_y  in  1  vertical flip.
REQ-013 width_select_in  in  1  width attribute, passed through.
REQ-014 hit_list_write_en  out  1  hit-list write strobe.
REQ-015 hit_list_index  out  IDX_W  hit-list write address.
REQ-016 sprite_id  out  ID_W  hit sprite ID.
REQ-017 sprite_y_intersect  out  6  row within sprite, 0-63.
REQ-018 width_select_out  out  1  registered width_select_in.
REQ-019 finished  out  1  terminator marker on the written entry.
REQ-020 busy  out  1  scan in progress.
REQ-021 overflow  out  1  hit list filled on the current line.
REQ-022 hit_count  out  IDX_W  hits written on the current line; terminator not counted.

Function
REQ-023 FSM SHALL have states IDLE, SCAN, TERMINATE, DONE; restart in any state SHALL move to SCAN at the next edge.
REQ-024 Restart SHALL latch render_y, zero sprite_test_id, hit_count and hit_list_index, and clear overflow.
REQ-025 Cycle numbering: cycle 0 is the first cycle in SCAN; sprite_test_id SHALL equal k in cycle k and increment by 1 per cycle up to SPRITE_COUNT-1.
REQ-026 Sprite k SHALL be evaluated in cycle k+1 using sprite_y, height_select, flip_y and width_select_in; any resulting write SHALL appear registered in cycle k+2.
REQ-027 diff = (latched render_y - sprite_y) mod 2^Y_WIDTH; hit when diff < (8 << height_select), so sprites wrap across the Y boundary.
REQ-028 sprite_y_intersect SHALL be diff[5:0] when flip_y=0, and (height-1-diff)[5:0] when flip_y=1.
REQ-029 On a hit: hit_list_write_en=1 for one cycle; hit_list_index = current hit_count; sprite_id = k; finished=0; hit_count increments the next cycle.
REQ-030 On a miss: hit_list_write_en=0.
REQ-031 When hit_count reaches HIT_LIST_DEPTH-1: overflow=1; further hits SHALL be discarded; state SHALL go to TERMINATE regardless of sprites remaining.
REQ-032 TERMINATE SHALL write one entry, then go to DONE in the next cycle: write_en=1, index=hit_count, finished=1, sprite_id=0, intersect=0, width=0.
REQ-033 Without overflow, the terminator write SHALL occur in cycle SPRITE_COUNT+2.
REQ-034 busy SHALL be 1 from cycle 0 through the terminator cycle inclusive, and 0 in IDLE and DONE.
REQ-035 When restart coincides with a pending hit or terminator write, restart SHALL win: that write SHALL be suppressed and the new scan SHALL begin.
REQ-036 hit_count and overflow SHALL hold their values in DONE until the next restart.
REQ-037 Each line SHALL have exactly one terminator write, and no write SHALL occur in IDLE or DONE.

Reset
REQ-038 reset_n=0 SHALL asynchronously force: state=IDLE; sprite_test_id, hit_list_index and hit_count to 0; write_en, finished, busy and overflow to 0; all data outputs to 0.
REQ-039 Reset asserted mid-SCAN SHALL abort the scan with no further writes; after release the block SHALL stay in IDLE until restart.

Verification
REQ-040 Defaults; render_y=20; only sprite 5 hits (y=15, height 8, no flip) -> one write in cycle 7: index 0, id 5, intersect 5; terminator index 1 in cycle 258; hit_count=1.
REQ-041 Same as REQ-040 with flip_y=1 -> intersect 2; with height_select=3 and sprite_y=500, render_y=10 -> wrap hit, intersect 22.
REQ-042 HIT_LIST_DEPTH=8; all 256 sprites hit -> writes at indices 0..6, terminator at index 7, overflow=1, hit_count=7, DONE entered well before cycle 258.
REQ-043 No hits -> single terminator at index 0 in cycle 258; busy high in cycles 0-258.
REQ-044 Restart pulsed at cycle 100 of a scan -> sprite_test_id returns to 0; no old-line terminator; new line completes normally.
REQ-045 reset_n pulled low at cycle 50 -> outputs 0 immediately; no writes after release until restart.
